// File: rtl/imem_stream.sv
// Instruction memory with a registered fetch port, a valid/ready program loader
// and an optional post-reset clear sequencer that fills the array with NOP_WORD.
module imem_stream #(
    parameter int unsigned       DATA_W         = 32,
    parameter int unsigned       ADDR_W         = 9,
    parameter logic [DATA_W-1:0] NOP_WORD       = '0,
    parameter bit                CLEAR_ON_RESET = 1'b1
) (
    input  logic              clka,
    input  logic              rst,
    // fetch port
    input  logic [ADDR_W-1:0] addra,
    input  logic              rd_en,
    output logic [DATA_W-1:0] douta,
    output logic              dvalid,
    // load port
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_valid,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {StClear, StIdle, StLoad, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              fetch;

    // Next-state, write-port and fetch-enable decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        we      = 1'b0;
        waddr   = cnt_q;
        wdata   = NOP_WORD;
        fetch   = 1'b0;
        unique case (state_q)
            StClear: begin
                we    = 1'b1;
                waddr = cnt_q;
                wdata = NOP_WORD;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                // A fetch in the same cycle as ld_start is still served.
                fetch = rd_en;
                if (ld_start) begin
                    state_d = StLoad;
                    ptr_d   = ld_base;
                end
            end
            StLoad: begin
                if (ld_valid) begin
                    we    = 1'b1;
                    waddr = ptr_q;
                    wdata = ld_data;
                    // Pointer wraps naturally at the ADDR_W boundary.
                    ptr_d = ptr_q + 1'b1;
                    if (ld_last) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, clear counter and load pointer registers
    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            if (CLEAR_ON_RESET) begin
                state_q <= StClear;
            end else begin
                state_q <= StIdle;
            end
            cnt_q <= '0;
            ptr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    // Memory array write port; the array itself is never reset
    always_ff @(posedge clka) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered fetch port; douta holds its value when no fetch is served
    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            douta  <= NOP_WORD;
            dvalid <= 1'b0;
        end else begin
            dvalid <= fetch;
            if (fetch) begin
                douta <= mem[addra];
            end
        end
    end

    assign ld_ready = (state_q == StLoad);
    assign ld_done  = (state_q == StDone);
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_imem_stream.sv
// Self-checking bench for imem_stream: a clearing instance (u1) and a
// non-clearing instance (u2) share all stimulus except reset, and both are
// compared every cycle against a session-level behavioural model.
module tb_imem_stream;

    localparam int DW    = 32;
    localparam int AW    = 9;
    localparam int DEPTH = 512;

    logic          clka = 1'b0;
    logic          rst1, rst2;
    logic [AW-1:0] addra, ld_base;
    logic          rd_en, ld_start, ld_valid, ld_last;
    logic [DW-1:0] ld_data;

    logic [DW-1:0] douta1, douta2;
    logic          dvalid1, dvalid2, ld_ready1, ld_ready2, ld_done1, ld_done2, busy1, busy2;

    imem_stream u1 (
        .clka(clka), .rst(rst1), .addra(addra), .rd_en(rd_en), .douta(douta1), .dvalid(dvalid1),
        .ld_start(ld_start), .ld_base(ld_base), .ld_data(ld_data), .ld_valid(ld_valid),
        .ld_last(ld_last), .ld_ready(ld_ready1), .ld_done(ld_done1), .busy(busy1)
    );

    imem_stream #(.CLEAR_ON_RESET(1'b0)) u2 (
        .clka(clka), .rst(rst2), .addra(addra), .rd_en(rd_en), .douta(douta2), .dvalid(dvalid2),
        .ld_start(ld_start), .ld_base(ld_base), .ld_data(ld_data), .ld_valid(ld_valid),
        .ld_last(ld_last), .ld_ready(ld_ready2), .ld_done(ld_done2), .busy(busy2)
    );

    always #5 clka = ~clka;

    int passed = 0;
    int total  = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem   [2][DEPTH];
    bit          m_known [2][DEPTH];
    int          m_clear_left [2];
    bit          m_in_sess [2], m_done [2], m_dvalid [2], m_dknown [2];
    logic [31:0] m_douta [2];
    int          m_ptr [2];
    int          m_accepts [2];

    function automatic bit m_busy(input int k);
        return (m_clear_left[k] > 0) || m_in_sess[k] || m_done[k];
    endfunction

    task automatic m_reset(input int k, input bit clr);
        m_clear_left[k] = clr ? DEPTH : 0;
        m_in_sess[k]    = 1'b0;
        m_done[k]       = 1'b0;
        m_dvalid[k]     = 1'b0;
        m_douta[k]      = 32'h0;
        m_dknown[k]     = 1'b1;
    endtask

    task automatic m_step(input int k);
        bit idle;
        idle        = !m_busy(k);
        m_dvalid[k] = idle && rd_en;
        if (m_dvalid[k]) begin
            m_douta[k]  = m_mem[k][addra];
            m_dknown[k] = m_known[k][addra];
        end
        if (m_clear_left[k] > 0) begin
            m_clear_left[k]--;
            if (m_clear_left[k] == 0) begin
                for (int i = 0; i < DEPTH; i++) begin
                    m_mem[k][i]   = 32'h0;
                    m_known[k][i] = 1'b1;
                end
            end
        end else if (m_done[k]) begin
            m_done[k] = 1'b0;
        end else if (m_in_sess[k]) begin
            if (ld_valid) begin
                m_mem[k][m_ptr[k]]   = ld_data;
                m_known[k][m_ptr[k]] = 1'b1;
                m_ptr[k]             = (m_ptr[k] + 1) % DEPTH;
                m_accepts[k]++;
                if (ld_last) begin
                    m_in_sess[k] = 1'b0;
                    m_done[k]    = 1'b1;
                end
            end
        end else if (ld_start) begin
            m_in_sess[k] = 1'b1;
            m_ptr[k]     = int'(ld_base);
        end
    endtask

    always @(posedge clka or negedge rst1) begin
        if (!rst1) m_reset(0, 1'b1);
        else       m_step(0);
    end

    always @(posedge clka or negedge rst2) begin
        if (!rst2) m_reset(1, 1'b0);
        else       m_step(1);
    end

    // ---------------- per-cycle compare ----------------
    int done_seen [2];

    task automatic cmp_inst(input int k, input logic [31:0] d, input logic dv, input logic rdy,
                            input logic dn, input logic bs);
        string p;
        p = (k == 0) ? "u1" : "u2";
        chk({p, " busy"}, bs, m_busy(k));
        chk({p, " ld_ready"}, rdy, m_in_sess[k]);
        chk({p, " ld_done"}, dn, m_done[k]);
        chk({p, " dvalid"}, dv, m_dvalid[k]);
        if (m_dknown[k]) chk({p, " douta"}, d, m_douta[k]);
        if (dn === 1'b1) done_seen[k]++;
    endtask

    always @(negedge clka) begin
        if (cmp_en) begin
            cmp_inst(0, douta1, dvalid1, ld_ready1, ld_done1, busy1);
            cmp_inst(1, douta2, dvalid2, ld_ready2, ld_done2, busy2);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic fetch(input int k, input logic [AW-1:0] a, input logic [31:0] exp,
                         input string nm);
        addra = a;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk({nm, " dvalid"}, (k == 0) ? dvalid1 : dvalid2, 1'b1);
        chk(nm, (k == 0) ? douta1 : douta2, exp);
    endtask

    task automatic start_load(input logic [AW-1:0] base);
        ld_start = 1'b1;
        ld_base  = base;
        tick();
        ld_start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input bit last, input int gap);
        ld_valid = 1'b0;
        repeat (gap) tick();
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    logic [31:0] w [6];
    int          busy_cnt, acc0, dn0, dn1;

    initial begin
        rst1 = 1'b0; rst2 = 1'b0;
        addra = '0; rd_en = 1'b0; ld_start = 1'b0; ld_base = '0;
        ld_data = '0; ld_valid = 1'b0; ld_last = 1'b0;
        #22;
        // Reset values
        chk("rst u1 busy", busy1, 1'b1);
        chk("rst u2 busy", busy2, 1'b0);
        chk("rst u1 douta", douta1, 32'h0);
        chk("rst u1 dvalid", dvalid1, 1'b0);
        chk("rst u1 ld_ready", ld_ready1, 1'b0);
        chk("rst u1 ld_done", ld_done1, 1'b0);

        // 1: clear sequence
        tick();
        rst1 = 1'b1; rst2 = 1'b1; cmp_en = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clka);
            if (busy1) busy_cnt++;
            else break;
        end
        chk("clear busy cycles", busy_cnt, 512);
        tick();
        fetch(0, 9'd0, 32'h0, "clr rd 0");
        fetch(0, 9'd255, 32'h0, "clr rd 255");
        fetch(0, 9'd511, 32'h0, "clr rd 511");

        // 2: six-word load at base 0
        dn0 = done_seen[0];
        for (int i = 0; i < 5; i++) w[i] = $urandom;
        w[5] = 32'h4A000000;
        start_load(9'd0);
        for (int i = 0; i < 6; i++) send_word(w[i], i == 5, 0);
        chk("t2 ld_done after last", ld_done1, 1'b1);
        tick();
        chk("t2 ld_done cleared", ld_done1, 1'b0);
        chk("t2 idle", busy1, 1'b0);
        chk("t2 done pulses", done_seen[0] - dn0, 1);
        chk("t2 model mem5", m_mem[0][5], 32'h4A000000);
        fetch(0, 9'd5, 32'h4A000000, "t2 rd 5");
        fetch(0, 9'd2, w[2], "t2 rd 2");

        // 3: gapped load
        acc0 = m_accepts[0];
        for (int i = 0; i < 4; i++) w[i] = $urandom;
        start_load(9'd40);
        for (int i = 0; i < 4; i++) send_word(w[i], i == 3, 3);
        tick();
        chk("t3 writes", m_accepts[0] - acc0, 4);
        fetch(0, 9'd39, 32'h0, "t3 rd 39");
        fetch(0, 9'd44, 32'h0, "t3 rd 44");
        fetch(0, 9'd41, w[1], "t3 rd 41");

        // 4: wrap-around load
        start_load(9'd510);
        send_word(32'hAAAA_0001, 1'b0, 0);
        send_word(32'hBBBB_0002, 1'b0, 0);
        send_word(32'hCCCC_0003, 1'b0, 0);
        send_word(32'hDDDD_0004, 1'b1, 0);
        tick();
        fetch(0, 9'd510, 32'hAAAA_0001, "t4 rd 510");
        fetch(0, 9'd511, 32'hBBBB_0002, "t4 rd 511");
        fetch(0, 9'd0, 32'hCCCC_0003, "t4 rd 0");
        fetch(0, 9'd1, 32'hDDDD_0004, "t4 rd 1");

        // 5: mid-load reset of the non-clearing instance
        dn1 = done_seen[1];
        w[0] = $urandom; w[1] = $urandom; w[2] = $urandom;
        start_load(9'd100);
        send_word(w[0], 1'b0, 0);
        send_word(w[1], 1'b0, 0);
        #2 rst2 = 1'b0;
        #1;
        chk("t5 async ld_ready", ld_ready2, 1'b0);
        chk("t5 async busy", busy2, 1'b0);
        chk("t5 async dvalid", dvalid2, 1'b0);
        chk("t5 async douta", douta2, 32'h0);
        tick();
        rst2 = 1'b1;
        send_word(w[2], 1'b1, 0);
        tick();
        chk("t5 u2 no ld_done", done_seen[1] - dn1, 0);
        fetch(1, 9'd100, w[0], "t5 u2 rd 100");
        fetch(1, 9'd101, w[1], "t5 u2 rd 101");
        fetch(0, 9'd102, w[2], "t5 u1 rd 102");

        // 6: rd_en held and a second ld_start during LOAD
        w[0] = $urandom; w[1] = $urandom;
        addra = 9'd7;
        rd_en = 1'b1;
        start_load(9'd200);
        send_word(w[0], 1'b0, 0);
        ld_start = 1'b1; ld_base = 9'd300;
        tick();
        ld_start = 1'b0;
        send_word(w[1], 1'b1, 0);
        rd_en = 1'b0;
        tick();
        fetch(0, 9'd200, w[0], "t6 rd 200");
        fetch(0, 9'd201, w[1], "t6 rd 201");
        fetch(0, 9'd300, 32'h0, "t6 rd 300");

        // Randomized traffic, checked by the per-cycle compare
        for (int i = 0; i < 600; i++) begin
            rd_en    = ($urandom_range(0, 1) == 1);
            addra    = AW'($urandom);
            ld_start = ($urandom_range(0, 15) == 0);
            ld_base  = AW'($urandom);
            ld_valid = ($urandom_range(0, 1) == 1);
            ld_last  = ($urandom_range(0, 7) == 0);
            ld_data  = $urandom;
            tick();
        end
        rd_en = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
